// File: rtl/if_fetch_unit.sv
// RV32I instruction-fetch stage: owns the PC, runs a req/ack fetch to instruction memory and holds the fetched word for the decoder.
// Optional misaligned-PC fault detection is compiled in with `define IF_MISALIGN_CHECK_EN.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INS  = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  output logic [31:0] ins,
  output logic        ins_valid,
  output logic [31:0] ins_pc,
  input  logic        ins_taken,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        busy,
  output logic        fetch_fault
);

  typedef enum logic [1:0] {IDLE, FETCH, FLUSH, HOLD} state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] pc;
  logic [31:0] pc_pending;
  logic        req_gap;     // forces one idle request cycle after a redirect that coincided with ack
  logic        misaligned;
  logic        fetch_live;

`ifdef IF_MISALIGN_CHECK_EN
  assign misaligned = (pc[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  // A request is only on the bus in FETCH when neither the gap cycle nor a fault is pending.
  assign fetch_live = (state == FETCH) && !req_gap && !misaligned;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (run) state_next = FETCH;
      end
      FETCH: begin
        if (misaligned) begin
          if (!redirect) state_next = HOLD;
        end else if (fetch_live) begin
          if (imem_ack)      state_next = redirect ? FETCH : HOLD;
          else if (redirect) state_next = FLUSH;
        end
      end
      FLUSH: begin
        if (imem_ack) state_next = run ? FETCH : IDLE;
      end
      HOLD: begin
        if (redirect || ins_taken) state_next = run ? FETCH : IDLE;
      end
    endcase
  end

  always_comb begin
    imem_req = fetch_live || (state == FLUSH);
    busy     = (state != IDLE);
`ifdef IF_MISALIGN_CHECK_EN
    imem_addr = pc;
`else
    imem_addr = {pc[31:2], 2'b00};
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc         <= RESET_PC;
      pc_pending <= RESET_PC;
      ins        <= NOP_INS;
      ins_pc     <= RESET_PC;
      ins_valid  <= 1'b0;
      req_gap    <= 1'b0;
    end else begin
      req_gap <= 1'b0;
      case (state)
        IDLE: begin
          if (redirect) pc <= redirect_pc;
        end
        FETCH: begin
          if (misaligned) begin
            if (redirect) begin
              pc <= redirect_pc;
            end else begin
              ins_pc    <= pc;
              ins       <= NOP_INS;
              ins_valid <= 1'b1;
            end
          end else if (!fetch_live) begin
            if (redirect) pc <= redirect_pc;
          end else if (imem_ack) begin
            if (redirect) begin
              pc      <= redirect_pc;
              req_gap <= 1'b1;
            end else begin
              ins       <= imem_rdata;
              ins_pc    <= pc;
              pc        <= pc + 32'd4;
              ins_valid <= 1'b1;
            end
          end else if (redirect) begin
            pc_pending <= redirect_pc;
          end
        end
        FLUSH: begin
          // The old address stays on the bus until ack; the returned word is dropped.
          if (imem_ack)      pc <= redirect ? redirect_pc : pc_pending;
          else if (redirect) pc_pending <= redirect_pc;
        end
        HOLD: begin
          if (redirect) begin
            pc        <= redirect_pc;
            ins       <= NOP_INS;
            ins_valid <= 1'b0;
          end else if (ins_taken) begin
            ins_valid <= 1'b0;
          end
        end
      endcase
    end
  end

`ifdef IF_MISALIGN_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_fault <= 1'b0;
    end else if ((state == FETCH) && misaligned && !redirect) begin
      fetch_fault <= 1'b1;
    end else if ((state == HOLD) && (redirect || ins_taken)) begin
      fetch_fault <= 1'b0;
    end
  end
`else
  assign fetch_fault = 1'b0;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed testbench for if_fetch_unit with a behavioural variable-latency instruction memory.
// Define IF_MISALIGN_CHECK_EN for both files to exercise the misaligned-PC fault path.
module tb_if_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        run;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ack;
  logic [31:0] ins;
  logic        ins_valid;
  logic [31:0] ins_pc;
  logic        ins_taken;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        busy;
  logic        fetch_fault;

  int checks;
  int failures;
  int mem_lat;
  int wait_cnt;

  if_fetch_unit dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_ack   (imem_ack),
    .ins        (ins),
    .ins_valid  (ins_valid),
    .ins_pc     (ins_pc),
    .ins_taken  (ins_taken),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .busy       (busy),
    .fetch_fault(fetch_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents: the test-plan word at address 0, a unique address-derived word elsewhere.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h0) ? 32'h0050_0093 : (32'h1000_0000 ^ a);
  endfunction

  // Memory responder: acks in the (mem_lat+1)-th cycle of a request.
  initial begin
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    wait_cnt   = 0;
    forever begin
      @(negedge clk);
      if (rst || !imem_req) begin
        imem_ack = 1'b0;
        wait_cnt = 0;
      end else if (wait_cnt >= mem_lat) begin
        imem_ack   = 1'b1;
        imem_rdata = mem_word(imem_addr);
        wait_cnt   = 0;
      end else begin
        imem_ack = 1'b0;
        wait_cnt++;
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; run = 1'b0; ins_taken = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_valid(input string name, input int budget);
    for (int i = 0; i < budget && !ins_valid; i++) @(negedge clk);
    checks++;
    if (ins_valid !== 1'b1) begin
      failures++;
      $display("FAIL %s: ins_valid never rose within %0d cycles", name, budget);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; run = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0400; ins_taken = 1'b1;
    mem_lat = 0;
    @(negedge clk);
    checks++;
    if ({imem_req, busy, ins_valid, fetch_fault} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_flags: req/busy/valid/fault=%b expected 0000", {imem_req, busy, ins_valid, fetch_fault});
    end
    checks++;
    if (ins !== NOP || ins_pc !== 32'h0 || imem_addr !== 32'h0) begin
      failures++;
      $display("FAIL reset_values: ins=%h ins_pc=%h addr=%h expected %h 0 0", ins, ins_pc, imem_addr, NOP);
    end
    rst = 1'b0; run = 1'b0; redirect = 1'b0; ins_taken = 1'b0;
  endtask

  task automatic test_zero_wait();
    do_reset();
    mem_lat = 0;
    run = 1'b1;
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0 || ins_valid !== 1'b0) begin
      failures++;
      $display("FAIL zw_req_cycle1: req=%b addr=%h valid=%b expected 1 0 0", imem_req, imem_addr, ins_valid);
    end
    @(negedge clk);
    checks++;
    if (ins_valid !== 1'b1 || ins !== 32'h0050_0093 || ins_pc !== 32'h0) begin
      failures++;
      $display("FAIL zw_valid_cycle2: valid=%b ins=%h pc=%h expected 1 00500093 0", ins_valid, ins, ins_pc);
    end
    checks++;
    if (imem_req !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL zw_hold: req=%b busy=%b expected 0 1", imem_req, busy);
    end
    ins_taken = 1'b1;
    @(negedge clk);
    ins_taken = 1'b0;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h4 || ins_valid !== 1'b0) begin
      failures++;
      $display("FAIL zw_next_fetch: req=%b addr=%h valid=%b expected 1 4 0", imem_req, imem_addr, ins_valid);
    end
    // With run low the outstanding fetch still lands, then take it to reach IDLE.
    run = 1'b0;
    @(negedge clk);
    checks++;
    if (ins_valid !== 1'b1 || ins_pc !== 32'h4 || ins !== mem_word(32'h4)) begin
      failures++;
      $display("FAIL run_low_complete: valid=%b pc=%h ins=%h expected 1 4 %h", ins_valid, ins_pc, ins, mem_word(32'h4));
    end
    ins_taken = 1'b1;
    @(negedge clk);
    ins_taken = 1'b0;
    checks++;
    if (busy !== 1'b0 || imem_req !== 1'b0 || ins_valid !== 1'b0) begin
      failures++;
      $display("FAIL run_low_idle: busy=%b req=%b valid=%b expected 0 0 0", busy, imem_req, ins_valid);
    end
  endtask

  task automatic test_wait_states();
    logic [31:0] rise_addr[$];
    logic [31:0] valid_pc[$];
    int          valid_cyc[$];
    logic        prev_req;
    logic [31:0] prev_addr;
    do_reset();
    mem_lat = 2; run = 1'b1; ins_taken = 1'b1;
    prev_req = 1'b0; prev_addr = 32'h0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (imem_req && !prev_req) rise_addr.push_back(imem_addr);
      if (imem_req && prev_req) begin
        checks++;
        if (imem_addr !== prev_addr) begin
          failures++;
          $display("FAIL ws_addr_stable: cycle %0d addr=%h expected %h", c, imem_addr, prev_addr);
        end
      end
      if (ins_valid) begin
        valid_cyc.push_back(c);
        valid_pc.push_back(ins_pc);
        checks++;
        if (ins !== mem_word(ins_pc)) begin
          failures++;
          $display("FAIL ws_ins_word: cycle %0d ins=%h expected %h", c, ins, mem_word(ins_pc));
        end
      end
      prev_req  = imem_req;
      prev_addr = imem_addr;
    end
    checks++;
    if (rise_addr.size() != 3 || rise_addr[0] !== 32'h0 || rise_addr[1] !== 32'h4 || rise_addr[2] !== 32'h8) begin
      failures++;
      $display("FAIL ws_addr_seq: got %p expected 0,4,8", rise_addr);
    end
    checks++;
    if (valid_cyc.size() != 3 || valid_cyc[0] != 4 || valid_cyc[1] != 8 || valid_cyc[2] != 12) begin
      failures++;
      $display("FAIL ws_valid_cycles: got %p expected 4,8,12", valid_cyc);
    end
    checks++;
    if (valid_pc.size() != 3 || valid_pc[0] !== 32'h0 || valid_pc[1] !== 32'h4 || valid_pc[2] !== 32'h8) begin
      failures++;
      $display("FAIL ws_valid_pcs: got %p expected 0,4,8", valid_pc);
    end
  endtask

  task automatic test_flush();
    do_reset();
    mem_lat = 2; run = 1'b1; ins_taken = 1'b1;
    for (int i = 0; i < 30 && !(imem_req && imem_addr == 32'h8); i++) @(negedge clk);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin
      failures++;
      $display("FAIL fl_reach_addr8: req=%b addr=%h expected 1 8", imem_req, imem_addr);
    end
    @(negedge clk);
    redirect = 1'b1; redirect_pc = 32'h0000_0100;
    @(negedge clk);
    redirect = 1'b0;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h8 || ins_valid !== 1'b0) begin
      failures++;
      $display("FAIL fl_old_addr_held: req=%b addr=%h valid=%b expected 1 8 0", imem_req, imem_addr, ins_valid);
    end
    @(negedge clk);
    checks++;
    if (ins_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin
      failures++;
      $display("FAIL fl_stale_dropped: valid=%b req=%b addr=%h expected 0 1 100", ins_valid, imem_req, imem_addr);
    end
    wait_valid("fl_new_valid", 10);
    checks++;
    if (ins_pc !== 32'h100 || ins !== mem_word(32'h100)) begin
      failures++;
      $display("FAIL fl_new_ins: pc=%h ins=%h expected 100 %h", ins_pc, ins, mem_word(32'h100));
    end
  endtask

  task automatic test_redirect_with_ack();
    do_reset();
    mem_lat = 0; run = 1'b1;
    @(negedge clk);
    redirect = 1'b1; redirect_pc = 32'h0000_0080;
    @(negedge clk);
    redirect = 1'b0;
    checks++;
    if (imem_req !== 1'b0 || ins_valid !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL ra_gap: req=%b valid=%b busy=%b expected 0 0 1", imem_req, ins_valid, busy);
    end
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h80) begin
      failures++;
      $display("FAIL ra_new_req: req=%b addr=%h expected 1 80", imem_req, imem_addr);
    end
    @(negedge clk);
    checks++;
    if (ins_valid !== 1'b1 || ins_pc !== 32'h80 || ins !== mem_word(32'h80)) begin
      failures++;
      $display("FAIL ra_new_ins: valid=%b pc=%h ins=%h expected 1 80 %h", ins_valid, ins_pc, ins, mem_word(32'h80));
    end
  endtask

  task automatic test_hold_redirect();
    do_reset();
    mem_lat = 0; run = 1'b1;
    wait_valid("hr_first_valid", 10);
    redirect = 1'b1; redirect_pc = 32'h0000_0040; ins_taken = 1'b1;
    @(negedge clk);
    redirect = 1'b0; ins_taken = 1'b0;
    checks++;
    if (ins_valid !== 1'b0 || ins !== NOP) begin
      failures++;
      $display("FAIL hr_flush_ins: valid=%b ins=%h expected 0 %h", ins_valid, ins, NOP);
    end
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin
      failures++;
      $display("FAIL hr_next_addr: req=%b addr=%h expected 1 40", imem_req, imem_addr);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    mem_lat = 0;
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    @(negedge clk);
    redirect = 1'b0;
    checks++;
    if (busy !== 1'b0 || imem_addr !== 32'hFFFF_FFFC) begin
      failures++;
      $display("FAIL wr_idle_redirect: busy=%b addr=%h expected 0 fffffffc", busy, imem_addr);
    end
    run = 1'b1; ins_taken = 1'b1;
    wait_valid("wr_valid", 10);
    checks++;
    if (ins_pc !== 32'hFFFF_FFFC) begin
      failures++;
      $display("FAIL wr_ins_pc: got %h expected fffffffc", ins_pc);
    end
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      failures++;
      $display("FAIL wr_next_addr: req=%b addr=%h expected 1 0", imem_req, imem_addr);
    end
  endtask

  task automatic test_reset_mid_fetch();
    do_reset();
    mem_lat = 5; run = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b1) begin
      failures++;
      $display("FAIL rm_in_fetch: req=%b expected 1", imem_req);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; run = 1'b0;
    checks++;
    if (imem_req !== 1'b0 || busy !== 1'b0 || ins_valid !== 1'b0 || imem_addr !== 32'h0) begin
      failures++;
      $display("FAIL rm_idle: req=%b busy=%b valid=%b addr=%h expected 0 0 0 0", imem_req, busy, ins_valid, imem_addr);
    end
  endtask

  task automatic test_misalign();
    do_reset();
    mem_lat = 0; run = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0102;
    @(negedge clk);
    redirect = 1'b0;
`ifdef IF_MISALIGN_CHECK_EN
    checks++;
    if (imem_req !== 1'b0) begin
      failures++;
      $display("FAIL ma_no_req: req=%b expected 0", imem_req);
    end
    @(negedge clk);
    checks++;
    if (fetch_fault !== 1'b1 || ins_valid !== 1'b1 || ins_pc !== 32'h102 || ins !== NOP || imem_req !== 1'b0) begin
      failures++;
      $display("FAIL ma_fault: fault=%b valid=%b pc=%h ins=%h req=%b expected 1 1 102 %h 0",
               fetch_fault, ins_valid, ins_pc, ins, imem_req, NOP);
    end
    run = 1'b0; ins_taken = 1'b1;
    @(negedge clk);
    ins_taken = 1'b0;
    checks++;
    if (fetch_fault !== 1'b0 || ins_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL ma_clear: fault=%b valid=%b busy=%b expected 0 0 0", fetch_fault, ins_valid, busy);
    end
`else
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h100 || fetch_fault !== 1'b0) begin
      failures++;
      $display("FAIL ma_aligned_addr: req=%b addr=%h fault=%b expected 1 100 0", imem_req, imem_addr, fetch_fault);
    end
`endif
  endtask

  initial begin
    checks = 0; failures = 0; mem_lat = 0;
    rst = 1'b1; run = 1'b0; ins_taken = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_flush();
    test_redirect_with_ack();
    test_hold_redirect();
    test_wrap();
    test_reset_mid_fetch();
    test_misalign();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
